hbm_mvm_head_cmd_gen: RTL and testbench
=======================================

Name: hbm_mvm_head_cmd_gen

Overview:
Parametrised multi-head command sequencer for the HBM MVM (after-F2W) path. One job covers all feature heads, including grouped-query heads where several feature heads share one weight head. KV-cache mode selects the weight row count, and long transfers are split into AXI-sized bursts. For each job it issues a strictly ordered stream of feature-read, weight-read and output-write commands (address, beat length, head id) to the HBM AXI master.

Parameters:
ADDR_W, 32, byte address width
BEAT_BYTES, 64, bytes per AXI beat (one token pixel per CH tile)
MAX_BURST, 256, maximum beats per issued command (power of 2)
HEAD_W, 6, width of head counters/ids
TOK_W, 16, width of token/row counts
TILE_W, 8, width of channel-tile counts

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  job start pulse; cfg_* sampled on the accepted cycle
cfg_feat_heads  in  HEAD_W  feature heads Hf
cfg_grp  in  HEAD_W  feature heads per weight head G
cfg_wt_heads  in  HEAD_W  weight heads Hw
cfg_tokens  in  TOK_W  feature rows per head (Token)
cfg_kv_mode  in  1  1: weight rows = cfg_kv_len, 0: weight rows = cfg_tokens
cfg_kv_len  in  TOK_W  cached KV length
cfg_in_tiles  in  TILE_W  CHin_div_Tout
cfg_out_tiles  in  TILE_W  CHout_div_Tout
cfg_dat_base, cfg_dat_head_stride, cfg_dat_surf_stride  in  ADDR_W  feature addressing
cfg_wt_base, cfg_wt_head_stride, cfg_wt_surf_stride  in  ADDR_W  weight addressing
cfg_out_base, cfg_out_head_stride, cfg_out_surf_stride  in  ADDR_W  output addressing
cmd_valid  out  1  command valid
cmd_ready  in  1  command accepted when valid&ready
cmd_type  out  2  0 feature read, 1 weight read, 2 output write
cmd_addr  out  ADDR_W  burst start byte address
cmd_len  out  8  beats-1
cmd_head  out  HEAD_W  feature head index (weight head for type 1)
cmd_last  out  1  final command of the job
busy  out  1  job in progress
done  out  1  one-cycle pulse after last command accepted
err  out  1  one-cycle pulse on rejected configuration

Behaviour:
- Reset: cmd_valid=0, busy=0, done=0, err=0, cmd_* =0, all counters and state = IDLE. Reset mid-job aborts immediately; no further commands are issued.
- States: IDLE -> CHK -> FEAT -> WT -> (next tile: FEAT | tiles done: OUT) -> (next head: FEAT | last head: FIN) -> IDLE.
- IDLE: start accepted only here; start while busy is ignored. On acceptance, latch cfg and set busy=1 on the next cycle.
- CHK (1 cycle): reject if Hf, G, Hw, cfg_in_tiles, cfg_out_tiles or cfg_tokens is 0; if Hw*G != Hf; or if cfg_kv_mode=1 and cfg_kv_len=0. On reject: err pulse, busy=0, return to IDLE, zero commands.
- Head loop h = 0..Hf-1, weight head w = h/G. w is computed without a divider: a group counter wraps at G and increments w on wrap.
- Tile loop c = 0..in_tiles-1:
  - FEAT: addr = dat_base + h*dat_head_stride + c*dat_surf_stride, total cfg_tokens beats.
  - WT: addr = wt_base + w*wt_head_stride + c*wt_surf_stride, total R beats, where R = kv_mode ? kv_len : tokens.
- OUT, t = 0..out_tiles-1: addr = out_base + h*out_head_stride + t*out_surf_stride, total cfg_tokens beats.
- Head and tile offsets are accumulated by adders, not multipliers. All address arithmetic wraps modulo 2^ADDR_W.
- Burst split: while remaining > MAX_BURST, issue cmd_len = MAX_BURST-1, advance addr by MAX_BURST*BEAT_BYTES and remaining by MAX_BURST. Final piece has cmd_len = remaining-1. A remaining count exactly equal to MAX_BURST yields a single command.
- Handshake: once cmd_valid is asserted, cmd_valid and all cmd_* stay stable until cmd_ready. The next command may be presented in the cycle after acceptance, so sustained throughput is 1 command/cycle with cmd_ready=1. cmd_ready asserted while cmd_valid=0 is ignored.
- cmd_last=1 only on the final OUT burst of head Hf-1. done pulses in the cycle after that command is accepted; busy falls in the same cycle, and the FSM returns to IDLE.
- Total command count = Hf*(in_tiles*(ceil(tokens/MAX_BURST)+ceil(R/MAX_BURST)) + out_tiles*ceil(tokens/MAX_BURST)).

Test Plan:
- Hf=4, G=2, Hw=2, tokens=49, kv_mode=0, tiles 1/1; dat_base=0, head strides 0x1000, wt_base=0x200_0000, out_base=0x800_0000 -> 12 cmds. Head 2: FEAT 0x2000 len 48, WT 0x200_1000 head 1 len 48, OUT 0x800_2000 len 48. cmd_last only on the 12th command; done one cycle later.
- tokens=300, MAX_BURST=256, Hf=G=Hw=1, tiles 1/1, dat_base=0 -> FEAT split into len 255 @0x0 and len 43 @0x4000 (WT and OUT split identically); exactly 256 tokens -> one len-255 command.
- kv_mode=1, kv_len=512, tokens=1 -> WT bursts len 255 @base and @base+0x4000; FEAT and OUT len 0.
- cmd_ready randomly deasserted for 0-5 cycles -> cmd_* stable while stalled, sequence identical to the unstalled run.
- Hf=4, G=2, Hw=3 -> err pulse, busy never set, no cmd_valid. A start while busy in test 1 changes nothing.
- rst asserted after the 5th accepted command -> all outputs 0 immediately; a new start reproduces the full sequence from command 1.

Source files
------------

// File: rtl/hbm_mvm_head_cmd_gen.sv
// Multi-head command sequencer for the HBM MVM path: walks heads, channel tiles and
// burst splits, emitting feature-read, weight-read and output-write commands in order.
module hbm_mvm_head_cmd_gen #(
    parameter int ADDR_W     = 32,
    parameter int BEAT_BYTES = 64,
    parameter int MAX_BURST  = 256,
    parameter int HEAD_W     = 6,
    parameter int TOK_W      = 16,
    parameter int TILE_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [HEAD_W-1:0] cfg_feat_heads,
    input  logic [HEAD_W-1:0] cfg_grp,
    input  logic [HEAD_W-1:0] cfg_wt_heads,
    input  logic [TOK_W-1:0]  cfg_tokens,
    input  logic              cfg_kv_mode,
    input  logic [TOK_W-1:0]  cfg_kv_len,
    input  logic [TILE_W-1:0] cfg_in_tiles,
    input  logic [TILE_W-1:0] cfg_out_tiles,
    input  logic [ADDR_W-1:0] cfg_dat_base,
    input  logic [ADDR_W-1:0] cfg_dat_head_stride,
    input  logic [ADDR_W-1:0] cfg_dat_surf_stride,
    input  logic [ADDR_W-1:0] cfg_wt_base,
    input  logic [ADDR_W-1:0] cfg_wt_head_stride,
    input  logic [ADDR_W-1:0] cfg_wt_surf_stride,
    input  logic [ADDR_W-1:0] cfg_out_base,
    input  logic [ADDR_W-1:0] cfg_out_head_stride,
    input  logic [ADDR_W-1:0] cfg_out_surf_stride,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [1:0]        cmd_type,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [7:0]        cmd_len,
    output logic [HEAD_W-1:0] cmd_head,
    output logic              cmd_last,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W-1:0] BURST_STEP = ADDR_W'(MAX_BURST * BEAT_BYTES);
    localparam logic [7:0]        FULL_LEN   = 8'(MAX_BURST - 1);
    localparam logic [TOK_W:0]    MAX_REM    = (TOK_W + 1)'(MAX_BURST);
    localparam logic [1:0]        TYPE_FEAT  = 2'd0;
    localparam logic [1:0]        TYPE_WT    = 2'd1;
    localparam logic [1:0]        TYPE_OUT   = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        CHK,
        FEAT,
        WT,
        OUT
    } state_e;

    state_e state_q;

    logic [HEAD_W-1:0] featHeads_q, grpSize_q;
    logic [TOK_W-1:0]  tokens_q, rows_q;
    logic [TILE_W-1:0] inTiles_q, outTiles_q;
    logic [ADDR_W-1:0] datBase_q, datHeadStride_q, datSurfStride_q;
    logic [ADDR_W-1:0] wtBase_q, wtHeadStride_q, wtSurfStride_q;
    logic [ADDR_W-1:0] outBase_q, outHeadStride_q, outSurfStride_q;
    logic              cfgOk_q;

    logic [HEAD_W-1:0] head_q, grpCnt_q, wHead_q;
    logic [TILE_W-1:0] tile_q, oTile_q;
    logic [ADDR_W-1:0] datHeadOff_q, wtHeadOff_q, outHeadOff_q;
    logic [ADDR_W-1:0] datTileOff_q, wtTileOff_q, outTileOff_q;
    logic [TOK_W-1:0]  rem_q;

    logic              cmdValid_q, cmdLast_q, busy_q, done_q, err_q;
    logic [1:0]        cmdType_q;
    logic [ADDR_W-1:0] cmdAddr_q;
    logic [7:0]        cmdLen_q;
    logic [HEAD_W-1:0] cmdHead_q;

    logic [2*HEAD_W-1:0] grpProd;
    logic                cfgOk;
    logic                accept, moreBursts, remNextFits, tokFits;
    logic                lastTile, lastOTile, nextOTileLast, lastHead, grpWrap;
    logic [TOK_W-1:0]    remNext;
    logic [7:0]          tokLen, rowLen, remNextLen;
    logic [ADDR_W-1:0]   datTileOff_d, wtTileOff_d, outTileOff_d;
    logic [ADDR_W-1:0]   datHeadOff_d, wtHeadOff_d, outHeadOff_d;

    function automatic logic fitsOne(input logic [TOK_W-1:0] rem);
        return {1'b0, rem} <= MAX_REM;
    endfunction

    function automatic logic [7:0] burstLen(input logic [TOK_W-1:0] rem);
        return fitsOne(rem) ? 8'(rem - 1'b1) : FULL_LEN;
    endfunction

    // Configuration is judged on the raw inputs so a rejected job never raises busy.
    always_comb begin
        grpProd = {{HEAD_W{1'b0}}, cfg_wt_heads} * {{HEAD_W{1'b0}}, cfg_grp};
        cfgOk   = (cfg_feat_heads != '0) && (cfg_grp != '0) && (cfg_wt_heads != '0) &&
                  (cfg_in_tiles != '0) && (cfg_out_tiles != '0) && (cfg_tokens != '0) &&
                  (grpProd == {{HEAD_W{1'b0}}, cfg_feat_heads}) &&
                  !(cfg_kv_mode && (cfg_kv_len == '0));
    end

    always_comb begin
        accept        = cmdValid_q & cmd_ready;
        moreBursts    = !fitsOne(rem_q);
        remNext       = rem_q - MAX_REM[TOK_W-1:0];
        remNextFits   = fitsOne(remNext);
        remNextLen    = burstLen(remNext);
        tokFits       = fitsOne(tokens_q);
        tokLen        = burstLen(tokens_q);
        rowLen        = burstLen(rows_q);
        lastTile      = (tile_q == inTiles_q - 1'b1);
        lastOTile     = (oTile_q == outTiles_q - 1'b1);
        nextOTileLast = ((oTile_q + 1'b1) == (outTiles_q - 1'b1));
        lastHead      = (head_q == featHeads_q - 1'b1);
        grpWrap       = (grpCnt_q == grpSize_q - 1'b1);
        datTileOff_d  = datTileOff_q + datSurfStride_q;
        wtTileOff_d   = wtTileOff_q + wtSurfStride_q;
        outTileOff_d  = outTileOff_q + outSurfStride_q;
        datHeadOff_d  = datHeadOff_q + datHeadStride_q;
        wtHeadOff_d   = wtHeadOff_q + wtHeadStride_q;
        outHeadOff_d  = outHeadOff_q + outHeadStride_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            featHeads_q     <= '0;
            grpSize_q       <= '0;
            tokens_q        <= '0;
            rows_q          <= '0;
            inTiles_q       <= '0;
            outTiles_q      <= '0;
            datBase_q       <= '0;
            datHeadStride_q <= '0;
            datSurfStride_q <= '0;
            wtBase_q        <= '0;
            wtHeadStride_q  <= '0;
            wtSurfStride_q  <= '0;
            outBase_q       <= '0;
            outHeadStride_q <= '0;
            outSurfStride_q <= '0;
            cfgOk_q         <= 1'b0;
            head_q          <= '0;
            grpCnt_q        <= '0;
            wHead_q         <= '0;
            tile_q          <= '0;
            oTile_q         <= '0;
            datHeadOff_q    <= '0;
            wtHeadOff_q     <= '0;
            outHeadOff_q    <= '0;
            datTileOff_q    <= '0;
            wtTileOff_q     <= '0;
            outTileOff_q    <= '0;
            rem_q           <= '0;
            cmdValid_q      <= 1'b0;
            cmdType_q       <= '0;
            cmdAddr_q       <= '0;
            cmdLen_q        <= '0;
            cmdHead_q       <= '0;
            cmdLast_q       <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            err_q           <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        featHeads_q     <= cfg_feat_heads;
                        grpSize_q       <= cfg_grp;
                        tokens_q        <= cfg_tokens;
                        rows_q          <= cfg_kv_mode ? cfg_kv_len : cfg_tokens;
                        inTiles_q       <= cfg_in_tiles;
                        outTiles_q      <= cfg_out_tiles;
                        datBase_q       <= cfg_dat_base;
                        datHeadStride_q <= cfg_dat_head_stride;
                        datSurfStride_q <= cfg_dat_surf_stride;
                        wtBase_q        <= cfg_wt_base;
                        wtHeadStride_q  <= cfg_wt_head_stride;
                        wtSurfStride_q  <= cfg_wt_surf_stride;
                        outBase_q       <= cfg_out_base;
                        outHeadStride_q <= cfg_out_head_stride;
                        outSurfStride_q <= cfg_out_surf_stride;
                        cfgOk_q         <= cfgOk;
                        busy_q          <= cfgOk;
                        state_q         <= CHK;
                    end
                end
                CHK: begin
                    if (!cfgOk_q) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        head_q       <= '0;
                        grpCnt_q     <= '0;
                        wHead_q      <= '0;
                        tile_q       <= '0;
                        oTile_q      <= '0;
                        datHeadOff_q <= '0;
                        wtHeadOff_q  <= '0;
                        outHeadOff_q <= '0;
                        datTileOff_q <= '0;
                        wtTileOff_q  <= '0;
                        outTileOff_q <= '0;
                        rem_q        <= tokens_q;
                        cmdValid_q   <= 1'b1;
                        cmdType_q    <= TYPE_FEAT;
                        cmdAddr_q    <= datBase_q;
                        cmdLen_q     <= tokLen;
                        cmdHead_q    <= '0;
                        cmdLast_q    <= 1'b0;
                        state_q      <= FEAT;
                    end
                end
                FEAT, WT, OUT: begin
                    if (accept) begin
                        if (moreBursts) begin
                            // Same segment, next burst; the final piece of the final OUT segment carries last.
                            rem_q     <= remNext;
                            cmdAddr_q <= cmdAddr_q + BURST_STEP;
                            cmdLen_q  <= remNextLen;
                            cmdLast_q <= (state_q == OUT) && lastOTile && lastHead && remNextFits;
                        end else begin
                            case (state_q)
                                FEAT: begin
                                    rem_q     <= rows_q;
                                    cmdType_q <= TYPE_WT;
                                    cmdAddr_q <= wtBase_q + wtHeadOff_q + wtTileOff_q;
                                    cmdLen_q  <= rowLen;
                                    cmdHead_q <= wHead_q;
                                    cmdLast_q <= 1'b0;
                                    state_q   <= WT;
                                end
                                WT: begin
                                    rem_q     <= tokens_q;
                                    cmdHead_q <= head_q;
                                    cmdLen_q  <= tokLen;
                                    if (!lastTile) begin
                                        tile_q       <= tile_q + 1'b1;
                                        datTileOff_q <= datTileOff_d;
                                        wtTileOff_q  <= wtTileOff_d;
                                        cmdType_q    <= TYPE_FEAT;
                                        cmdAddr_q    <= datBase_q + datHeadOff_q + datTileOff_d;
                                        cmdLast_q    <= 1'b0;
                                        state_q      <= FEAT;
                                    end else begin
                                        tile_q       <= '0;
                                        datTileOff_q <= '0;
                                        wtTileOff_q  <= '0;
                                        cmdType_q    <= TYPE_OUT;
                                        cmdAddr_q    <= outBase_q + outHeadOff_q + outTileOff_q;
                                        cmdLast_q    <= lastHead && lastOTile && tokFits;
                                        state_q      <= OUT;
                                    end
                                end
                                default: begin
                                    if (!lastOTile) begin
                                        oTile_q      <= oTile_q + 1'b1;
                                        outTileOff_q <= outTileOff_d;
                                        rem_q        <= tokens_q;
                                        cmdAddr_q    <= outBase_q + outHeadOff_q + outTileOff_d;
                                        cmdLen_q     <= tokLen;
                                        cmdLast_q    <= lastHead && nextOTileLast && tokFits;
                                    end else if (!lastHead) begin
                                        // Weight head advances only when the group counter wraps.
                                        oTile_q      <= '0;
                                        outTileOff_q <= '0;
                                        head_q       <= head_q + 1'b1;
                                        datHeadOff_q <= datHeadOff_d;
                                        outHeadOff_q <= outHeadOff_d;
                                        if (grpWrap) begin
                                            grpCnt_q    <= '0;
                                            wHead_q     <= wHead_q + 1'b1;
                                            wtHeadOff_q <= wtHeadOff_d;
                                        end else begin
                                            grpCnt_q <= grpCnt_q + 1'b1;
                                        end
                                        rem_q     <= tokens_q;
                                        cmdType_q <= TYPE_FEAT;
                                        cmdAddr_q <= datBase_q + datHeadOff_d;
                                        cmdLen_q  <= tokLen;
                                        cmdHead_q <= head_q + 1'b1;
                                        cmdLast_q <= 1'b0;
                                        state_q   <= FEAT;
                                    end else begin
                                        cmdValid_q <= 1'b0;
                                        cmdLast_q  <= 1'b0;
                                        busy_q     <= 1'b0;
                                        done_q     <= 1'b1;
                                        state_q    <= IDLE;
                                    end
                                end
                            endcase
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_valid = cmdValid_q;
    assign cmd_type  = cmdType_q;
    assign cmd_addr  = cmdAddr_q;
    assign cmd_len   = cmdLen_q;
    assign cmd_head  = cmdHead_q;
    assign cmd_last  = cmdLast_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_hbm_mvm_head_cmd_gen.sv
// Bench for hbm_mvm_head_cmd_gen: a table of directed jobs and random jobs, each command
// checked against a loop-nest reference model of the head/tile/burst ordering.
module tb_hbm_mvm_head_cmd_gen;

    localparam int ADDR_W     = 32;
    localparam int BEAT_BYTES = 64;
    localparam int MAX_BURST  = 256;
    localparam int HEAD_W     = 6;
    localparam int TOK_W      = 16;
    localparam int TILE_W     = 8;
    localparam int BUDGET     = 20000;

    logic              clk = 1'b0;
    logic              rst, start, cmdReady;
    logic [HEAD_W-1:0] cfgFeatHeads, cfgGrp, cfgWtHeads;
    logic [TOK_W-1:0]  cfgTokens, cfgKvLen;
    logic              cfgKvMode;
    logic [TILE_W-1:0] cfgInTiles, cfgOutTiles;
    logic [ADDR_W-1:0] cfgDatBase, cfgDatHs, cfgDatSs, cfgWtBase, cfgWtHs, cfgWtSs;
    logic [ADDR_W-1:0] cfgOutBase, cfgOutHs, cfgOutSs;
    logic              cmdValid, cmdLast, busy, done, err;
    logic [1:0]        cmdType;
    logic [ADDR_W-1:0] cmdAddr;
    logic [7:0]        cmdLen;
    logic [HEAD_W-1:0] cmdHead;

    always #5 clk = ~clk;

    hbm_mvm_head_cmd_gen #(
        .ADDR_W(ADDR_W), .BEAT_BYTES(BEAT_BYTES), .MAX_BURST(MAX_BURST),
        .HEAD_W(HEAD_W), .TOK_W(TOK_W), .TILE_W(TILE_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_feat_heads(cfgFeatHeads), .cfg_grp(cfgGrp), .cfg_wt_heads(cfgWtHeads),
        .cfg_tokens(cfgTokens), .cfg_kv_mode(cfgKvMode), .cfg_kv_len(cfgKvLen),
        .cfg_in_tiles(cfgInTiles), .cfg_out_tiles(cfgOutTiles),
        .cfg_dat_base(cfgDatBase), .cfg_dat_head_stride(cfgDatHs), .cfg_dat_surf_stride(cfgDatSs),
        .cfg_wt_base(cfgWtBase), .cfg_wt_head_stride(cfgWtHs), .cfg_wt_surf_stride(cfgWtSs),
        .cfg_out_base(cfgOutBase), .cfg_out_head_stride(cfgOutHs), .cfg_out_surf_stride(cfgOutSs),
        .cmd_valid(cmdValid), .cmd_ready(cmdReady), .cmd_type(cmdType), .cmd_addr(cmdAddr),
        .cmd_len(cmdLen), .cmd_head(cmdHead), .cmd_last(cmdLast),
        .busy(busy), .done(done), .err(err)
    );

    typedef struct {
        int          hf, g, hw, tokens, kvMode, kvLen, inT, outT;
        logic [31:0] datBase, datHs, datSs, wtBase, wtHs, wtSs, outBase, outHs, outSs;
        int          expCount;
        bit          expErr;
    } job_t;

    job_t        jobs[8];
    logic [48:0] expQ[$];
    logic [48:0] gotQ[$];
    int          nCompared   = 0;
    int          nMismatched = 0;

    function automatic logic [48:0] packCmd(input logic [1:0] t, input logic [31:0] a,
                                            input logic [7:0] l, input logic [5:0] h,
                                            input logic last);
        return {t, a, l, h, last};
    endfunction

    function automatic logic [52:0] outsPacked();
        return {cmdValid, busy, done, err, cmdType, cmdAddr, cmdLen, cmdHead, cmdLast};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkGot(input int idx, input logic [48:0] exp, input string name);
        if (idx < gotQ.size()) checkOutput(name, {15'd0, gotQ[idx]}, {15'd0, exp});
        else begin
            nCompared++;
            nMismatched++;
            $display("[TB] FAIL %s: command %0d never issued, required 0x%0h", name, idx, exp);
        end
    endtask

    // One transfer, cut into MAX_BURST-beat pieces.
    task automatic pushSplit(input logic [1:0] t, input logic [31:0] a0, input int n, input int head);
        int          rem = n;
        logic [31:0] a   = a0;
        while (rem > 0) begin
            int piece = (rem > MAX_BURST) ? MAX_BURST : rem;
            expQ.push_back(packCmd(t, a, 8'(piece - 1), 6'(head), 1'b0));
            a   = a + 32'(MAX_BURST * BEAT_BYTES);
            rem = rem - piece;
        end
    endtask

    task automatic buildModel(input job_t j);
        logic [48:0] tail;
        int          rows;
        expQ.delete();
        if (j.expErr) return;
        rows = (j.kvMode != 0) ? j.kvLen : j.tokens;
        for (int h = 0; h < j.hf; h++) begin
            int w = h / j.g;
            for (int c = 0; c < j.inT; c++) begin
                pushSplit(2'd0, j.datBase + 32'(h) * j.datHs + 32'(c) * j.datSs, j.tokens, h);
                pushSplit(2'd1, j.wtBase + 32'(w) * j.wtHs + 32'(c) * j.wtSs, rows, w);
            end
            for (int t = 0; t < j.outT; t++)
                pushSplit(2'd2, j.outBase + 32'(h) * j.outHs + 32'(t) * j.outSs, j.tokens, h);
        end
        tail    = expQ.pop_back();
        tail[0] = 1'b1;
        expQ.push_back(tail);
    endtask

    task automatic driveCfg(input job_t j);
        cfgFeatHeads = 6'(j.hf);
        cfgGrp       = 6'(j.g);
        cfgWtHeads   = 6'(j.hw);
        cfgTokens    = 16'(j.tokens);
        cfgKvMode    = (j.kvMode != 0);
        cfgKvLen     = 16'(j.kvLen);
        cfgInTiles   = 8'(j.inT);
        cfgOutTiles  = 8'(j.outT);
        cfgDatBase   = j.datBase;
        cfgDatHs     = j.datHs;
        cfgDatSs     = j.datSs;
        cfgWtBase    = j.wtBase;
        cfgWtHs      = j.wtHs;
        cfgWtSs      = j.wtSs;
        cfgOutBase   = j.outBase;
        cfgOutHs     = j.outHs;
        cfgOutSs     = j.outSs;
    endtask

    task automatic applyStimulus(input job_t j, input int stallMax, input int resetAfter,
                                 input bit pokeStart);
        int          accepted = 0, errSeen = 0, stallLeft = 0, cyc = 0, vb = 0, expCount;
        bit          lastAcc = 0, stalled = 0, finished = 0, doReset = 0, pokeActive = 0;
        logic [48:0] snap, cur;
        buildModel(j);
        expCount = (j.expCount >= 0) ? j.expCount : expQ.size();
        gotQ.delete();
        driveCfg(j);
        cmdReady = 1'b1;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("busyAfterStart", {63'd0, busy}, {63'd0, !j.expErr});
        if (j.expErr) begin
            for (int i = 0; i < 8; i++) begin
                if (err) errSeen++;
                if (cmdValid || busy) vb++;
                @(negedge clk);
            end
            checkOutput("errPulseCount", 64'(errSeen), 64'd1);
            checkOutput("noCmdOnReject", 64'(vb), 64'd0);
            return;
        end
        while (!finished && cyc < BUDGET) begin
            if (err) errSeen++;
            cur = packCmd(cmdType, cmdAddr, cmdLen, cmdHead, cmdLast);
            if (lastAcc) begin
                checkOutput("doneAfterLast", {61'd0, done, busy, cmdValid}, 64'b100);
                finished = 1;
            end else begin
                if (done) checkOutput("earlyDone", {63'd0, done}, 64'd0);
                if (stalled) checkOutput("stallStable", {15'd0, cur}, {15'd0, snap});
                if (stallLeft > 0) begin
                    cmdReady = 1'b0;
                    stallLeft--;
                end else begin
                    cmdReady = 1'b1;
                end
                stalled = 0;
                if (cmdValid && cmdReady) begin
                    gotQ.push_back(cur);
                    if (accepted < expQ.size())
                        checkOutput($sformatf("cmd%0d", accepted), {15'd0, cur}, {15'd0, expQ[accepted]});
                    else
                        checkOutput("extraCmd", 64'(accepted), 64'(expQ.size()));
                    accepted++;
                    lastAcc   = (accepted == expQ.size());
                    stallLeft = (stallMax > 0) ? int'($urandom_range(0, stallMax)) : 0;
                    if (pokeStart && accepted == 3) begin
                        start      = 1'b1;
                        cfgTokens  = cfgTokens + 16'd7;
                        cfgWtHeads = 6'd3;
                        pokeActive = 1;
                    end
                    if (resetAfter > 0 && accepted == resetAfter) doReset = 1;
                end else if (cmdValid) begin
                    stalled = 1;
                    snap    = cur;
                end
                @(negedge clk);
                cyc++;
                if (pokeActive) begin
                    start = 1'b0;
                    driveCfg(j);
                    pokeActive = 0;
                end
                if (doReset) begin
                    rst = 1'b1;
                    #1;
                    checkOutput("resetMidJob", {11'd0, outsPacked()}, 64'd0);
                    @(negedge clk);
                    rst = 1'b0;
                    @(negedge clk);
                    checkOutput("idleAfterAbort", {11'd0, outsPacked()}, 64'd0);
                    return;
                end
            end
        end
        if (!finished) begin
            nCompared++;
            nMismatched++;
            $display("[TB] FAIL jobTimeout: %0d commands after %0d cycles, required %0d", accepted, cyc, expCount);
        end else begin
            @(negedge clk);
            checkOutput("donePulseWidth", {63'd0, done}, 64'd0);
        end
        checkOutput("cmdCount", 64'(accepted), 64'(expCount));
        checkOutput("noErrOnGoodJob", 64'(errSeen), 64'd0);
    endtask

    initial begin
        job_t rj;
        rst = 1'b1;
        start = 1'b0;
        cmdReady = 1'b0;
        rj = '{hf:0, g:0, hw:0, tokens:0, kvMode:0, kvLen:0, inT:0, outT:0,
               datBase:0, datHs:0, datSs:0, wtBase:0, wtHs:0, wtSs:0,
               outBase:0, outHs:0, outSs:0, expCount:0, expErr:1'b0};
        driveCfg(rj);
        repeat (2) @(negedge clk);
        checkOutput("resetState", {11'd0, outsPacked()}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idleAfterReset", {11'd0, outsPacked()}, 64'd0);

        jobs[0] = '{hf:4, g:2, hw:2, tokens:49, kvMode:0, kvLen:0, inT:1, outT:1,
                    datBase:32'h0, datHs:32'h1000, datSs:32'h100,
                    wtBase:32'h0200_0000, wtHs:32'h1000, wtSs:32'h100,
                    outBase:32'h0800_0000, outHs:32'h1000, outSs:32'h100, expCount:12, expErr:1'b0};
        jobs[1] = '{hf:1, g:1, hw:1, tokens:300, kvMode:0, kvLen:0, inT:1, outT:1,
                    datBase:32'h0, datHs:32'h1000, datSs:32'h0,
                    wtBase:32'h0001_0000, wtHs:32'h0, wtSs:32'h0,
                    outBase:32'h0002_0000, outHs:32'h0, outSs:32'h0, expCount:6, expErr:1'b0};
        jobs[2] = jobs[1];
        jobs[2].tokens = 256;
        jobs[2].expCount = 3;
        jobs[3] = jobs[1];
        jobs[3].tokens = 1;
        jobs[3].kvMode = 1;
        jobs[3].kvLen = 512;
        jobs[3].expCount = 4;
        jobs[4] = jobs[0];
        jobs[4].hw = 3;
        jobs[4].expCount = 0;
        jobs[4].expErr = 1'b1;
        jobs[5] = jobs[1];
        jobs[5].tokens = 0;
        jobs[5].expCount = 0;
        jobs[5].expErr = 1'b1;
        jobs[6] = jobs[3];
        jobs[6].kvLen = 0;
        jobs[6].expCount = 0;
        jobs[6].expErr = 1'b1;
        jobs[7] = '{hf:2, g:1, hw:2, tokens:10, kvMode:0, kvLen:0, inT:2, outT:3,
                    datBase:32'hFFFF_F000, datHs:32'h800, datSs:32'h400,
                    wtBase:32'h3000_0000, wtHs:32'h2000, wtSs:32'h40,
                    outBase:32'h5000_0000, outHs:32'h1_0000, outSs:32'h200, expCount:14, expErr:1'b0};

        for (int i = 0; i < 8; i++) begin
            applyStimulus(jobs[i], 0, 0, i == 0);
            if (i == 0) begin
                checkGot(6,  packCmd(2'd0, 32'h0000_2000, 8'd48, 6'd2, 1'b0), "t1Head2Feat");
                checkGot(7,  packCmd(2'd1, 32'h0200_1000, 8'd48, 6'd1, 1'b0), "t1Head2Wt");
                checkGot(8,  packCmd(2'd2, 32'h0800_2000, 8'd48, 6'd2, 1'b0), "t1Head2Out");
                checkGot(11, packCmd(2'd2, 32'h0800_3000, 8'd48, 6'd3, 1'b1), "t1LastOut");
            end else if (i == 1) begin
                checkGot(0, packCmd(2'd0, 32'h0000_0000, 8'd255, 6'd0, 1'b0), "splitFeat0");
                checkGot(1, packCmd(2'd0, 32'h0000_4000, 8'd43,  6'd0, 1'b0), "splitFeat1");
                checkGot(3, packCmd(2'd1, 32'h0001_4000, 8'd43,  6'd0, 1'b0), "splitWt1");
                checkGot(5, packCmd(2'd2, 32'h0002_4000, 8'd43,  6'd0, 1'b1), "splitOut1");
            end else if (i == 2) begin
                checkGot(0, packCmd(2'd0, 32'h0000_0000, 8'd255, 6'd0, 1'b0), "exact256Feat");
            end else if (i == 3) begin
                checkGot(0, packCmd(2'd0, 32'h0000_0000, 8'd0,   6'd0, 1'b0), "kvFeat");
                checkGot(1, packCmd(2'd1, 32'h0001_0000, 8'd255, 6'd0, 1'b0), "kvWt0");
                checkGot(2, packCmd(2'd1, 32'h0001_4000, 8'd255, 6'd0, 1'b0), "kvWt1");
                checkGot(3, packCmd(2'd2, 32'h0002_0000, 8'd0,   6'd0, 1'b1), "kvOut");
            end
        end

        applyStimulus(jobs[0], 5, 0, 1'b0);
        applyStimulus(jobs[1], 5, 0, 1'b0);
        applyStimulus(jobs[0], 0, 5, 1'b0);
        applyStimulus(jobs[0], 0, 0, 1'b0);

        for (int k = 0; k < 6; k++) begin
            rj.hw       = int'($urandom_range(1, 3));
            rj.g        = int'($urandom_range(1, 3));
            rj.hf       = rj.hw * rj.g;
            rj.tokens   = int'($urandom_range(1, 600));
            rj.kvMode   = int'($urandom_range(0, 1));
            rj.kvLen    = int'($urandom_range(1, 700));
            rj.inT      = int'($urandom_range(1, 3));
            rj.outT     = int'($urandom_range(1, 2));
            rj.datBase  = $urandom;
            rj.datHs    = $urandom;
            rj.datSs    = $urandom;
            rj.wtBase   = $urandom;
            rj.wtHs     = $urandom;
            rj.wtSs     = $urandom;
            rj.outBase  = $urandom;
            rj.outHs    = $urandom;
            rj.outSs    = $urandom;
            rj.expCount = -1;
            rj.expErr   = 1'b0;
            applyStimulus(rj, int'($urandom_range(0, 5)), 0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
